// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
// The SRAM_TURNAROUND_EN macro (see sram_ctrl.sv) uses the TURN state.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER,
        TURN
    } sram_state_t;

    localparam int DATA_W_DEF      = 16;
    localparam int SRAM_ADDR_W_DEF = 20;
    localparam int WAIT_CYCLES_MAX = 15;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/sram_ctrl_dq_io.sv
// Tristate driver for the SRAM DQ bus. Output data and enable are registered
// here so that the bus has exactly one driver, which comes straight from flops.
module sram_dq_io
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              oe_d,
    input  logic [DATA_W-1:0] out_d,
    output logic [DATA_W-1:0] dq_in,
    inout  wire  [DATA_W-1:0] dq
);

    logic              oe_q;
    logic [DATA_W-1:0] out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_q  <= 1'b0;
            out_q <= '0;
        end else begin
            oe_q  <= oe_d;
            out_q <= out_d;
        end
    end

    assign dq    = oe_q ? out_q : {DATA_W{1'bz}};
    assign dq_in = dq;

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: valid/ready request port to registered CE/OE/WE/BE/ADDR/DQ pins.
// Optional macro SRAM_TURNAROUND_EN adds a dead TURN cycle after every write.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 16,
    parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
    parameter int WAIT_CYCLES = 0,
    localparam int BE_W       = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [BE_W-1:0]        req_be,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic [BE_W-1:0]        SRAM_BE_N,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0]      SRAM_DQ
);

    sram_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic [BE_W-1:0]        be_n_q, be_n_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic                   dq_oe_d;
    logic [DATA_W-1:0]      dq_out_d;
    logic [DATA_W-1:0]      dq_in;
    logic                   hs;

    assign req_ready = (state_q == IDLE) && !rst;
    assign hs        = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    if (!we_q) rdata_d = dq_in;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                state_d = IDLE;
`ifdef SRAM_TURNAROUND_EN
                if (we_q) state_d = TURN;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Pins are decoded from the next state so the registered outputs line up with the state itself.
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        be_n_d      = '1;
        sram_addr_d = sram_addr_q;
        dq_oe_d     = 1'b0;
        dq_out_d    = wdata_d;
        rsp_valid_d = (state_d == RECOVER);

        if (state_d == ACCESS) begin
            ce_n_d      = 1'b0;
            be_n_d      = ~be_d;
            sram_addr_d = SRAM_ADDR_W'(addr_d);
            if (we_d) begin
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end else begin
                oe_n_d  = 1'b0;
            end
        end else if (state_d == RECOVER && we_d) begin
            dq_oe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= '1;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    sram_dq_io #(.DATA_W(DATA_W)) u_dq (
        .clk   (clk),
        .rst   (rst),
        .oe_d  (dq_oe_d),
        .out_d (dq_out_d),
        .dq_in (dq_in),
        .dq    (SRAM_DQ)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_BE_N = be_n_q;
    assign SRAM_ADDR = sram_addr_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances (WAIT 0, WAIT 3, 32-bit WAIT 2)
// with a shared behavioural SRAM behind the two 16-bit instances.
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // instance a: 16-bit, WAIT_CYCLES=0
    logic        a_valid, a_we, a_ready, a_rsp;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic [1:0]  a_be, a_be_n;
    logic        a_ce_n, a_oe_n, a_we_n;
    logic [19:0] a_saddr;
    wire  [15:0] a_dq;

    // instance b: 16-bit, WAIT_CYCLES=3
    logic        b_valid, b_we, b_ready, b_rsp;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic [1:0]  b_be, b_be_n;
    logic        b_ce_n, b_oe_n, b_we_n;
    logic [19:0] b_saddr;
    wire  [15:0] b_dq;

    // instance c: 32-bit data, 18-bit address, WAIT_CYCLES=2, no SRAM model
    logic        c_valid, c_we, c_ready, c_rsp;
    logic [17:0] c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic [3:0]  c_be, c_be_n;
    logic        c_ce_n, c_oe_n, c_we_n;
    logic [19:0] c_saddr;
    wire  [31:0] c_dq;

    sram_ctrl #(.DATA_W(16), .ADDR_W(16), .SRAM_ADDR_W(20), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be), .rsp_valid(a_rsp),
        .rsp_rdata(a_rdata), .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n), .SRAM_WE_N(a_we_n),
        .SRAM_BE_N(a_be_n), .SRAM_ADDR(a_saddr), .SRAM_DQ(a_dq));

    sram_ctrl #(.DATA_W(16), .ADDR_W(16), .SRAM_ADDR_W(20), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .rsp_valid(b_rsp),
        .rsp_rdata(b_rdata), .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n),
        .SRAM_BE_N(b_be_n), .SRAM_ADDR(b_saddr), .SRAM_DQ(b_dq));

    sram_ctrl #(.DATA_W(32), .ADDR_W(18), .SRAM_ADDR_W(20), .WAIT_CYCLES(2)) dut_c (
        .clk(clk), .rst(rst), .req_valid(c_valid), .req_ready(c_ready), .req_we(c_we),
        .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be), .rsp_valid(c_rsp),
        .rsp_rdata(c_rdata), .SRAM_CE_N(c_ce_n), .SRAM_OE_N(c_oe_n), .SRAM_WE_N(c_we_n),
        .SRAM_BE_N(c_be_n), .SRAM_ADDR(c_saddr), .SRAM_DQ(c_dq));

    // behavioural asynchronous SRAM shared by a and b (256 words, low address bits)
    logic [15:0] mem [0:255];

    assign a_dq = (!a_ce_n && !a_oe_n && a_we_n) ? mem[a_saddr[7:0]] : 16'hzzzz;
    assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? mem[b_saddr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!a_ce_n && !a_we_n && !a_be_n[i]) mem[a_saddr[7:0]][i*8 +: 8] <= a_dq[i*8 +: 8];
            if (!b_ce_n && !b_we_n && !b_be_n[i]) mem[b_saddr[7:0]][i*8 +: 8] <= b_dq[i*8 +: 8];
        end
    end

    // controller driving DQ while the SRAM output is enabled would be bus contention
    bit contention = 1'b0;
    always @(negedge clk) begin
        if ((!a_oe_n && dut_a.u_dq.oe_q) || (!b_oe_n && dut_b.u_dq.oe_q)) contention = 1'b1;
    end

`ifdef SRAM_TURNAROUND_EN
    localparam bit TURN_ON = 1'b1;
`else
    localparam bit TURN_ON = 1'b0;
`endif

    int  gap;
    bit  seen;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst = 1'b1;
        a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
        c_valid = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0;
        repeat (2) @(negedge clk);

        chk("rst_ce_n",  a_ce_n, 1'b1);
        chk("rst_oe_n",  a_oe_n, 1'b1);
        chk("rst_we_n",  a_we_n, 1'b1);
        chk("rst_be_n",  a_be_n, 2'b11);
        chk("rst_addr",  a_saddr, 20'h0);
        chk("rst_dq_oe", dut_a.u_dq.oe_q, 1'b0);
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_rsp",   a_rsp, 1'b0);
        chk("rst_rdata", a_rdata, 16'h0);

        rst = 1'b0;
        #1 chk("ready_after_rst", a_ready, 1'b1);

        // reset in the middle of a 32-bit write
        @(negedge clk);
        c_valid = 1; c_we = 1; c_addr = 18'h3ABCD; c_wdata = 32'hCAFEF00D; c_be = 4'b1010;
        chk("c_ready_idle", c_ready, 1'b1);
        @(negedge clk);
        c_valid = 0;
        chk("c_acc_we_n", c_we_n, 1'b0);
        chk("c_acc_ce_n", c_ce_n, 1'b0);
        chk("c_acc_be_n", c_be_n, 4'b0101);
        chk("c_acc_addr", c_saddr, 20'h3ABCD);
        chk("c_acc_dq",   c_dq, 32'hCAFEF00D);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("c_arst_ce_n",  c_ce_n, 1'b1);
        chk("c_arst_we_n",  c_we_n, 1'b1);
        chk("c_arst_be_n",  c_be_n, 4'b1111);
        chk("c_arst_addr",  c_saddr, 20'h0);
        chk("c_arst_dq_oe", dut_c.u_dq.oe_q, 1'b0);
        chk("c_arst_ready", c_ready, 1'b0);
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("c_ready_after_rst", c_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (c_rsp) seen = 1'b1;
        end
        chk("c_no_rsp_after_abort", seen, 1'b0);

        // full 32-bit write: 3 ACCESS cycles, response in the 4th
        @(negedge clk);
        c_valid = 1; c_we = 1; c_addr = 18'h20001; c_wdata = 32'h1234_5678; c_be = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c_valid = 0;
            chk("c_sw_be_n", c_be_n, 4'b0101);
            chk("c_sw_addr", c_saddr, 20'h20001);
            chk("c_sw_rsp0", c_rsp, 1'b0);
        end
        @(negedge clk);
        chk("c_sw_rsp1", c_rsp, 1'b1);
        chk("c_sw_hold", c_dq, 32'h1234_5678);
        chk("c_sw_ce_n", c_ce_n, 1'b1);
        repeat (2) @(negedge clk);

        // write 0xBEEF to 0x0123 on a
        a_valid = 1; a_we = 1; a_addr = 16'h0123; a_wdata = 16'hBEEF; a_be = 2'b11;
        chk("a_w_ready", a_ready, 1'b1);
        @(negedge clk);
        a_valid = 0;
        chk("a_w_we_n", a_we_n, 1'b0);
        chk("a_w_ce_n", a_ce_n, 1'b0);
        chk("a_w_oe_n", a_oe_n, 1'b1);
        chk("a_w_be_n", a_be_n, 2'b00);
        chk("a_w_addr", a_saddr, 20'h00123);
        chk("a_w_dq",   a_dq, 16'hBEEF);
        chk("a_w_rsp0", a_rsp, 1'b0);
        @(negedge clk);
        chk("a_r_we_n", a_we_n, 1'b1);
        chk("a_r_ce_n", a_ce_n, 1'b1);
        chk("a_r_be_n", a_be_n, 2'b11);
        chk("a_r_dq",   a_dq, 16'hBEEF);
        chk("a_r_rsp1", a_rsp, 1'b1);
        @(negedge clk);
        chk("a_i_rsp0",  a_rsp, 1'b0);
        chk("a_i_dq_oe", dut_a.u_dq.oe_q, 1'b0);
        chk("a_i_ready", a_ready, !TURN_ON);
        chk("a_i_rdata", a_rdata, 16'h0);
        repeat (2) @(negedge clk);

        // read back on b, WAIT_CYCLES=3
        b_valid = 1; b_we = 0; b_addr = 16'h0123; b_be = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_valid = 0;
            chk("b_rd_oe_n", b_oe_n, 1'b0);
            chk("b_rd_rsp0", b_rsp, 1'b0);
        end
        @(negedge clk);
        chk("b_rd_rsp1",  b_rsp, 1'b1);
        chk("b_rd_rdata", b_rdata, 16'hBEEF);
        chk("b_rd_oe_hi", b_oe_n, 1'b1);
        @(negedge clk);
        chk("b_rd_rsp_end", b_rsp, 1'b0);
        chk("b_rd_hold",    b_rdata, 16'hBEEF);

        // byte-lane write of the low byte on a, then read on b
        @(negedge clk);
        a_valid = 1; a_we = 1; a_addr = 16'h0123; a_wdata = 16'h12AB; a_be = 2'b01;
        @(negedge clk);
        a_valid = 0;
        chk("a_bw_be_n", a_be_n, 2'b10);
        repeat (3) @(negedge clk);
        b_valid = 1; b_we = 0; b_addr = 16'h0123; b_be = 2'b11;
        @(negedge clk);
        b_valid = 0;
        repeat (4) @(negedge clk);
        chk("b_bw_rsp",   b_rsp, 1'b1);
        chk("b_bw_rdata", b_rdata, 16'hBEAB);
        repeat (2) @(negedge clk);

        // back-to-back write then read on a with req_valid held high
        a_valid = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 16'h5555; a_be = 2'b11;
        chk("a_bb_ready", a_ready, 1'b1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) begin
                a_we = 0; a_wdata = 16'h0000;
            end
        end while (!a_ready && gap < 12);
        chk("a_bb_gap", gap, TURN_ON ? 4 : 3);
        @(negedge clk);
        a_valid = 0;
        chk("a_bb_oe_n", a_oe_n, 1'b0);
        @(negedge clk);
        chk("a_bb_rsp",   a_rsp, 1'b1);
        chk("a_bb_rdata", a_rdata, 16'h5555);
        repeat (2) @(negedge clk);
        chk("no_contention", contention, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
